lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store controller sitting directly upstream of the data memory `memory`. `memory` has a 64-word, word-only write port.
- Accepts one byte/half/word load or store per request from the execute stage via a valid/ready handshake.
- Drives the memory's `DM_Addr`/`Mem_Write`/write-data port. Performs read-modify-write for sub-word stores, and extracts plus sign/zero-extends load data from `M_R_Data`.
- Returns results on a one-cycle response strobe. Misaligned accesses are flagged as errors.

Parameters:
- DM_AW, 6, word-address width of data memory (64 words); byte address width = DM_AW+2
- DW, 32, data width; fixed at 32, must not be changed

Ports:
- clk_dm  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (IDLE only)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  DM_AW+2  byte address; [DM_AW+1:2]=word index, [1:0]=byte offset
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion strobe
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned/illegal access; qualified by resp_valid
- DM_Addr  out  DM_AW  word address to data memory (registered)
- DM_W_Data  out  32  write data to data memory
- Mem_Write  out  1  data-memory write enable; memory writes at rising clk_dm while high
- M_R_Data  in  32  data-memory read data; combinational from DM_Addr

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE
  - DM_Addr=0, DM_W_Data=0, resp_rdata=0
  - resp_valid=0, resp_err=0, Mem_Write=0
  - req_ready=1 from the first cycle after release
- Reset mid-operation: any pending op is discarded. A sub-word store in progress is never written, and Mem_Write is low from the reset edge onward.
- Byte ordering: little-endian. Offset k selects bits [8k+7:8k]; half offset 2 selects [31:16].
- Misalignment, detected in IDLE at accept:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
- State machine (Mem_Write=(state==WR); resp_valid=(state==RESP or ERR)):
  - IDLE: req_ready=1. On req_valid, latch all request fields and load DM_Addr=addr[DM_AW+1:2]. Then:
    - misaligned -> ERR
    - load -> RD
    - word store -> WR, with DM_W_Data=req_wdata
    - sub-word store -> RMW
  - RD: sample M_R_Data, extract the lane and extend it into resp_rdata -> RESP.
  - RMW: sample M_R_Data, replace only the addressed byte/half lane with req_wdata, load the result into DM_W_Data -> WR.
  - WR: Mem_Write=1 for exactly one cycle; DM_Addr and DM_W_Data held stable -> RESP.
  - RESP: resp_valid=1, resp_err=0; resp_rdata=0 for stores -> IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0. Memory is never written -> IDLE.
- req_ready=0 outside IDLE; req_valid is ignored there. Requests never overlap; back-to-back requests are accepted on the cycle after RESP/ERR.
- Latency, request accepted at edge N:
  - load: resp_valid during cycle N+2
  - word store: Mem_Write during N+1, resp during N+2
  - sub-word store: RMW N+1, WR N+2, resp N+3
  - error: resp during N+1
- Address range: the top word (index 2^DM_AW-1) and byte address 0xFF are legal. There is no wrap beyond the top word because the address is truncated to its width.
- Outside WR, DM_W_Data holds its last value; only Mem_Write qualifies it.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W
  - state enum {IDLE, RD, RMW, WR, RESP, ERR}
  - DM_AW default
- Sub-module lsu_align (combinational):
  - inputs: word, offset, size, unsigned, wdata
  - outputs: extended load data, merged store word, misalign flag
  - lsu_ctrl holds the FSM and registers.

Test Plan:
- Word store addr 0x04, data 0x12345678 -> Mem_Write high exactly one cycle (N+1) with DM_Addr=1, DM_W_Data=0x12345678. resp_valid at N+2, resp_rdata=0, resp_err=0.
- Word 1 preset 0x80FF7F01; signed byte load addr 0x07 -> resp_rdata=0xFFFFFF80 at N+2. Unsigned -> 0x00000080. Signed byte at 0x05 -> 0x0000007F. Signed half at 0x04 -> 0x00007F01.
- Word 1 = 0x12345678; half store 0xBEEF at addr 0x06 -> RMW reads 0x12345678, WR writes 0xBEEF5678 at N+2, resp at N+3. A following word load of 0x04 returns 0xBEEF5678.
- Word load addr 0x05, half load addr 0x03, size=11 at 0x00 -> each gives resp_valid+resp_err at N+1, resp_rdata=0. Mem_Write never asserted, memory unchanged.
- Byte store 0xAA at 0x09 with rst_n pulled low during the RMW cycle -> no Mem_Write, all outputs 0 after the edge, word 2 unchanged. req_ready=1 the cycle after release, and a new load completes normally.
- Top-word access: word store 0xCAFEF00D at 0xFC, then unsigned byte load at 0xFF -> DM_Addr=63, resp_rdata=0x000000CA. req_valid held high during busy cycles is not double-accepted.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared size encodings, FSM state type and defaults for lsu_ctrl
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

   localparam int unsigned C_DM_AW_DEF = 6;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      RMW  = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4,
      ERR  = 3'd5
   } lsu_state_e;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Brief    : Little-endian lane extract/extend, sub-word merge, misalign check
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_word,
   output logic        o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [4:0]  w_bit_pos;

   assign w_bit_pos = {i_offset, 3'b000};
   assign w_byte    = i_word[w_bit_pos +: 8];
   assign w_half    = i_offset[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_load_data = i_word;
      case (i_size)
         SZ_B:    o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         SZ_H:    o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
         default: o_load_data = i_word;
      endcase
   end

   // Only the addressed lane is replaced; the rest comes from the read word
   always_comb begin
      o_store_word = i_word;
      case (i_size)
         SZ_B: o_store_word[w_bit_pos +: 8] = i_wdata[7:0];
         SZ_H: begin
            if (i_offset[1]) o_store_word[31:16] = i_wdata[15:0];
            else             o_store_word[15:0]  = i_wdata[15:0];
         end
         default: o_store_word = i_wdata;
      endcase
   end

   always_comb begin
      o_misalign = 1'b1;
      case (i_size)
         SZ_B:    o_misalign = 1'b0;
         SZ_H:    o_misalign = i_offset[0];
         SZ_W:    o_misalign = |i_offset;
         default: o_misalign = 1'b1;
      endcase
   end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Brief    : Load/store controller in front of a word-only data memory
//  Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int DM_AW = C_DM_AW_DEF,
   parameter int DW    = 32
)(
   input  logic             clk_dm,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [DM_AW+1:0] req_addr,
   input  logic [DW-1:0]    req_wdata,
   output logic             resp_valid,
   output logic [DW-1:0]    resp_rdata,
   output logic             resp_err,
   output logic [DM_AW-1:0] DM_Addr,
   output logic [DW-1:0]    DM_W_Data,
   output logic             Mem_Write,
   input  logic [DW-1:0]    M_R_Data
);

   lsu_state_e       r_state;
   lsu_state_e       w_state_nxt;
   logic             w_accept;

   logic [1:0]       r_size;
   logic [1:0]       r_offset;
   logic             r_unsigned;
   logic [DW-1:0]    r_wdata;
   logic [DM_AW-1:0] r_dm_addr;
   logic [DW-1:0]    r_dm_wdata;
   logic [DW-1:0]    r_rdata;

   logic [1:0]       w_al_size;
   logic [1:0]       w_al_offset;
   logic [DW-1:0]    w_load_data;
   logic [DW-1:0]    w_store_word;
   logic             w_misalign;

   // In IDLE the aligner judges the incoming request; afterwards the latched one
   assign w_al_size   = (r_state == IDLE) ? req_size       : r_size;
   assign w_al_offset = (r_state == IDLE) ? req_addr[1:0]  : r_offset;

   lsu_align u_align (
      .i_word       (M_R_Data),
      .i_offset     (w_al_offset),
      .i_size       (w_al_size),
      .i_unsigned   (r_unsigned),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word),
      .o_misalign   (w_misalign)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      req_ready   = 1'b0;
      Mem_Write   = 1'b0;
      resp_valid  = 1'b0;
      resp_err    = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept = 1'b1;
               if (w_misalign)           w_state_nxt = ERR;
               else if (!req_we)         w_state_nxt = RD;
               else if (req_size == SZ_W) w_state_nxt = WR;
               else                      w_state_nxt = RMW;
            end
         end
         RD:   w_state_nxt = RESP;
         RMW:  w_state_nxt = WR;
         WR: begin
            Mem_Write   = 1'b1;
            w_state_nxt = RESP;
         end
         RESP: begin
            resp_valid  = 1'b1;
            w_state_nxt = IDLE;
         end
         ERR: begin
            resp_valid  = 1'b1;
            resp_err    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_dm) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_size     <= '0;
         r_offset   <= '0;
         r_unsigned <= 1'b0;
         r_wdata    <= '0;
         r_dm_addr  <= '0;
         r_dm_wdata <= '0;
         r_rdata    <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_size     <= req_size;
                  r_offset   <= req_addr[1:0];
                  r_unsigned <= req_unsigned;
                  r_wdata    <= req_wdata;
                  r_dm_addr  <= req_addr[DM_AW+1:2];
                  r_rdata    <= '0;
                  if (w_state_nxt == WR) r_dm_wdata <= req_wdata;
               end
            end
            RD:      r_rdata    <= w_load_data;
            RMW:     r_dm_wdata <= w_store_word;
            default: ;
         endcase
      end
   end

   assign DM_Addr    = r_dm_addr;
   assign DM_W_Data  = r_dm_wdata;
   assign resp_rdata = r_rdata;

endmodule : lsu_ctrl
`default_nettype wire
